// File: rtl/iob_axi_bridge_pkg.sv
// Shared constants for iob_axi_bridge: FSM states, AXI burst/response codes and
// the beat-size encoding helper. Also supplies defaults for DDR_ADDR_W and DATA_W.
`ifndef DDR_ADDR_W
`define DDR_ADDR_W 32
`endif
`ifndef DATA_W
`define DATA_W 32
`endif

package iob_axi_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      WR_ADDR_DATA = 3'd1,
      WR_RESP      = 3'd2,
      RD_ADDR      = 3'd3,
      RD_DATA      = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10
   } axi_burst_t;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_t;

   // AXI AxSIZE encodes bytes-per-beat as log2.
   function automatic logic [2:0] axi_size(input int data_w);
      return 3'($clog2(data_w / 8));
   endfunction

endpackage

// File: rtl/iob_axi_bridge.sv
// Native (valid/ready) to AXI4 single-beat initiator, one transaction in flight.
// Define IOB_AXI_BRIDGE_ERR_EN to make non-OKAY responses set the sticky err flag.
`ifndef DDR_ADDR_W
`define DDR_ADDR_W 32
`endif
`ifndef DATA_W
`define DATA_W 32
`endif

module iob_axi_bridge
   import iob_axi_bridge_pkg::*;
#(
   parameter int AXI_ID_W   = 4,
   parameter int AXI_LEN_W  = 8,
   parameter int AXI_ADDR_W = `DDR_ADDR_W,
   parameter int AXI_DATA_W = `DATA_W
) (
   input  logic                    clk,
   input  logic                    rst,

   input  logic                    valid,
   input  logic [AXI_ADDR_W-1:0]   addr,
   input  logic [AXI_DATA_W-1:0]   wdata,
   input  logic [AXI_DATA_W/8-1:0] wstrb,
   output logic [AXI_DATA_W-1:0]   rdata,
   output logic                    ready,

   output logic [AXI_ID_W-1:0]     m_axi_awid,
   output logic [AXI_ADDR_W-1:0]   m_axi_awaddr,
   output logic [AXI_LEN_W-1:0]    m_axi_awlen,
   output logic [2:0]              m_axi_awsize,
   output logic [1:0]              m_axi_awburst,
   output logic                    m_axi_awlock,
   output logic [3:0]              m_axi_awcache,
   output logic [2:0]              m_axi_awprot,
   output logic [3:0]              m_axi_awqos,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,

   output logic [AXI_DATA_W-1:0]   m_axi_wdata,
   output logic [AXI_DATA_W/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wlast,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,

   input  logic [AXI_ID_W-1:0]     m_axi_bid,
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,

   output logic [AXI_ID_W-1:0]     m_axi_arid,
   output logic [AXI_ADDR_W-1:0]   m_axi_araddr,
   output logic [AXI_LEN_W-1:0]    m_axi_arlen,
   output logic [2:0]              m_axi_arsize,
   output logic [1:0]              m_axi_arburst,
   output logic                    m_axi_arlock,
   output logic [3:0]              m_axi_arcache,
   output logic [2:0]              m_axi_arprot,
   output logic [3:0]              m_axi_arqos,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,

   input  logic [AXI_ID_W-1:0]     m_axi_rid,
   input  logic [AXI_DATA_W-1:0]   m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rlast,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready,

   output logic                    err
);

   localparam int                    STRB_W    = AXI_DATA_W / 8;
   localparam int                    SIZE_BITS = $clog2(STRB_W);
   localparam logic [2:0]            BEAT_SIZE = axi_size(AXI_DATA_W);
   localparam logic [AXI_ADDR_W-1:0] ADDR_MASK = ~(AXI_ADDR_W'((1 << SIZE_BITS) - 1));

   state_t                  state;
   logic [AXI_ADDR_W-1:0]   addr_q;
   logic [AXI_DATA_W-1:0]   wdata_q;
   logic [STRB_W-1:0]       wstrb_q;
   logic [AXI_DATA_W-1:0]   rdata_q;
   logic                    awvalid_q;
   logic                    wvalid_q;
   logic                    bready_q;
   logic                    arvalid_q;
   logic                    rready_q;
   logic                    ready_q;
   logic                    start;
   logic                    aw_done;
   logic                    w_done;

   // While ready is high the host is still presenting the request just completed,
   // so a new one is only accepted once the completion pulse has gone.
   assign start   = (state == IDLE) && valid && !ready_q;
   assign aw_done = !awvalid_q || m_axi_awready;
   assign w_done  = !wvalid_q || m_axi_wready;

   // Request payload is captured once per transaction and needs no reset.
   always_ff @(posedge clk) begin
      if (start) begin
         addr_q  <= addr & ADDR_MASK;
         wdata_q <= wdata;
         wstrb_q <= wstrb;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         ready_q   <= 1'b0;
         rdata_q   <= '0;
      end else begin
         ready_q <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (|wstrb) begin
                     state     <= WR_ADDR_DATA;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                  end else begin
                     state     <= RD_ADDR;
                     arvalid_q <= 1'b1;
                  end
               end
            end
            WR_ADDR_DATA: begin
               // Address and data channels complete independently, in any order.
               if (m_axi_awready) awvalid_q <= 1'b0;
               if (m_axi_wready)  wvalid_q  <= 1'b0;
               if (aw_done && w_done) begin
                  state    <= WR_RESP;
                  bready_q <= 1'b1;
               end
            end
            WR_RESP: begin
               if (m_axi_bvalid) begin
                  state    <= IDLE;
                  bready_q <= 1'b0;
                  ready_q  <= 1'b1;
               end
            end
            RD_ADDR: begin
               if (m_axi_arready) begin
                  state     <= RD_DATA;
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
               end
            end
            RD_DATA: begin
               if (m_axi_rvalid) begin
                  state    <= IDLE;
                  rready_q <= 1'b0;
                  rdata_q  <= m_axi_rdata;
                  ready_q  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rdata = rdata_q;
   assign ready = ready_q;

   assign m_axi_awid    = '0;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awlen   = '0;
   assign m_axi_awsize  = BEAT_SIZE;
   assign m_axi_awburst = BURST_INCR;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awcache = '0;
   assign m_axi_awprot  = '0;
   assign m_axi_awqos   = '0;
   assign m_axi_awvalid = awvalid_q;

   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_wlast   = 1'b1;
   assign m_axi_wvalid  = wvalid_q;

   assign m_axi_bready  = bready_q;

   assign m_axi_arid    = '0;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arlen   = '0;
   assign m_axi_arsize  = BEAT_SIZE;
   assign m_axi_arburst = BURST_INCR;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = '0;
   assign m_axi_arprot  = '0;
   assign m_axi_arqos   = '0;
   assign m_axi_arvalid = arvalid_q;

   assign m_axi_rready  = rready_q;

`ifdef IOB_AXI_BRIDGE_ERR_EN
   logic err_q;
   logic unused_in;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if ((state == WR_RESP && m_axi_bvalid && m_axi_bresp != RESP_OKAY) ||
                   (state == RD_DATA && m_axi_rvalid && m_axi_rresp != RESP_OKAY)) begin
         err_q <= 1'b1;
      end
   end

   assign err       = err_q;
   assign unused_in = ^{m_axi_bid, m_axi_rid, m_axi_rlast};
`else
   logic unused_in;

   assign err       = 1'b0;
   assign unused_in = ^{m_axi_bid, m_axi_rid, m_axi_rlast, m_axi_bresp, m_axi_rresp};
`endif

endmodule

// File: tb/tb_iob_axi_bridge.sv
// Bench for iob_axi_bridge: behavioural AXI RAM subordinate with programmable stalls,
// reference word memory, directed scenarios followed by randomized transactions.
module tb_iob_axi_bridge;

   localparam int IW = 4;
   localparam int LW = 8;
   localparam int AW = 32;
   localparam int DW = 32;

`ifdef IOB_AXI_BRIDGE_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          valid;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [3:0]    wstrb;
   logic [DW-1:0] rdata;
   logic          ready;
   logic          err;

   logic [IW-1:0] m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
   logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
   logic [LW-1:0] m_axi_awlen, m_axi_arlen;
   logic [2:0]    m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
   logic [1:0]    m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
   logic          m_axi_awlock, m_axi_arlock;
   logic [3:0]    m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos;
   logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_wlast;
   logic [DW-1:0] m_axi_wdata, m_axi_rdata;
   logic [3:0]    m_axi_wstrb;
   logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
   logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;

   iob_axi_bridge #(
      .AXI_ID_W(IW), .AXI_LEN_W(LW), .AXI_ADDR_W(AW), .AXI_DATA_W(DW)
   ) dut (
      .clk(clk), .rst(rst), .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
      .rdata(rdata), .ready(ready),
      .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
      .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
      .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
      .m_axi_bready(m_axi_bready),
      .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
      .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- AXI RAM subordinate (16 words) ----------------
   int            aw_delay, w_delay, ar_delay, r_delay;
   logic          inj_r, inj_b;
   int            aw_wait, w_wait, ar_wait, r_cnt;
   logic          have_aw, have_w, r_pend;
   logic [AW-1:0] aw_addr_q, r_addr_q, last_awaddr, last_araddr;
   logic [DW-1:0] w_data_q;
   logic [3:0]    w_strb_q;
   logic [DW-1:0] mem [0:15];
   logic          aw_hs, w_hs, ar_hs, wr_go;
   logic [AW-1:0] wr_addr_sel;
   logic [DW-1:0] wr_data_sel;
   logic [3:0]    wr_strb_sel;

   assign m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
   assign m_axi_wready  = m_axi_wvalid && (w_wait >= w_delay);
   assign m_axi_arready = m_axi_arvalid && (ar_wait >= ar_delay);
   assign aw_hs = m_axi_awvalid && m_axi_awready;
   assign w_hs  = m_axi_wvalid && m_axi_wready;
   assign ar_hs = m_axi_arvalid && m_axi_arready;
   assign wr_go = (have_aw || aw_hs) && (have_w || w_hs);
   assign wr_addr_sel = have_aw ? aw_addr_q : m_axi_awaddr;
   assign wr_data_sel = have_w ? w_data_q : m_axi_wdata;
   assign wr_strb_sel = have_w ? w_strb_q : m_axi_wstrb;
   assign m_axi_bid   = '0;
   assign m_axi_rid   = '0;
   assign m_axi_rlast = m_axi_rvalid;

   always @(posedge clk) begin
      if (rst) begin
         aw_wait <= 0; w_wait <= 0; ar_wait <= 0; r_cnt <= 0;
         have_aw <= 1'b0; have_w <= 1'b0; r_pend <= 1'b0;
         m_axi_bvalid <= 1'b0; m_axi_rvalid <= 1'b0;
         m_axi_bresp <= 2'b00; m_axi_rresp <= 2'b00; m_axi_rdata <= '0;
      end else begin
         aw_wait <= (m_axi_awvalid && !m_axi_awready) ? aw_wait + 1 : 0;
         w_wait  <= (m_axi_wvalid && !m_axi_wready) ? w_wait + 1 : 0;
         ar_wait <= (m_axi_arvalid && !m_axi_arready) ? ar_wait + 1 : 0;
         if (aw_hs) begin
            have_aw <= 1'b1; aw_addr_q <= m_axi_awaddr; last_awaddr <= m_axi_awaddr;
         end
         if (w_hs) begin
            have_w <= 1'b1; w_data_q <= m_axi_wdata; w_strb_q <= m_axi_wstrb;
         end
         if (wr_go) begin
            for (int b = 0; b < 4; b++)
               if (wr_strb_sel[b]) mem[wr_addr_sel[5:2]][8*b +: 8] <= wr_data_sel[8*b +: 8];
            have_aw <= 1'b0; have_w <= 1'b0;
            m_axi_bvalid <= 1'b1;
            m_axi_bresp  <= inj_b ? 2'b10 : 2'b00;
         end else if (m_axi_bvalid && m_axi_bready) begin
            m_axi_bvalid <= 1'b0;
         end
         if (ar_hs) begin
            last_araddr <= m_axi_araddr;
            if (r_delay == 0) begin
               m_axi_rvalid <= 1'b1; m_axi_rdata <= mem[m_axi_araddr[5:2]];
               m_axi_rresp  <= inj_r ? 2'b10 : 2'b00;
            end else begin
               r_pend <= 1'b1; r_cnt <= 1; r_addr_q <= m_axi_araddr;
            end
         end else if (r_pend) begin
            if (r_cnt >= r_delay) begin
               m_axi_rvalid <= 1'b1; m_axi_rdata <= mem[r_addr_q[5:2]];
               m_axi_rresp  <= inj_r ? 2'b10 : 2'b00;
               r_pend <= 1'b0;
            end else begin
               r_cnt <= r_cnt + 1;
            end
         end
         if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
      end
   end

   // ---------------- protocol monitor: fixed attributes, stable payload ----------------
   int            proto_err;
   logic          aw_hold, w_hold, ar_hold;
   logic [AW-1:0] aw_prev, ar_prev;
   logic [DW-1:0] w_prev;
   logic [3:0]    ws_prev;
   logic          aw_bad, w_bad, ar_bad;

   assign aw_bad = (m_axi_awvalid && (m_axi_awlen != 0 || m_axi_awsize != 3'd2 ||
                    m_axi_awburst != 2'b01 || m_axi_awid != 0 || m_axi_awlock ||
                    m_axi_awcache != 0 || m_axi_awprot != 0 || m_axi_awqos != 0 ||
                    m_axi_awaddr[1:0] != 2'b00 || (aw_hold && m_axi_awaddr != aw_prev))) ||
                   (aw_hold && !m_axi_awvalid);
   assign w_bad  = (m_axi_wvalid && (!m_axi_wlast ||
                    (w_hold && (m_axi_wdata != w_prev || m_axi_wstrb != ws_prev)))) ||
                   (w_hold && !m_axi_wvalid);
   assign ar_bad = (m_axi_arvalid && (m_axi_arlen != 0 || m_axi_arsize != 3'd2 ||
                    m_axi_arburst != 2'b01 || m_axi_arid != 0 || m_axi_arlock ||
                    m_axi_arcache != 0 || m_axi_arprot != 0 || m_axi_arqos != 0 ||
                    m_axi_araddr[1:0] != 2'b00 || (ar_hold && m_axi_araddr != ar_prev))) ||
                   (ar_hold && !m_axi_arvalid);

   initial proto_err = 0;
   always @(posedge clk) begin
      if (rst) begin
         aw_hold <= 1'b0; w_hold <= 1'b0; ar_hold <= 1'b0;
      end else begin
         if (aw_bad || w_bad || ar_bad) proto_err <= proto_err + 1;
         aw_hold <= m_axi_awvalid && !m_axi_awready;
         w_hold  <= m_axi_wvalid && !m_axi_wready;
         ar_hold <= m_axi_arvalid && !m_axi_arready;
         aw_prev <= m_axi_awaddr; ar_prev <= m_axi_araddr;
         w_prev  <= m_axi_wdata;  ws_prev <= m_axi_wstrb;
      end
   end

   // ---------------- checking helpers and reference model ----------------
   int            checks;
   int            failures;
   logic [DW-1:0] ref_mem [0:15];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic run_txn(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                          output logic [DW-1:0] rd, output int lat, output int aw_cyc,
                          output int w_cyc, output int pulses);
      logic done;
      valid = 1'b1; addr = a; wdata = d; wstrb = s;
      lat = 0; aw_cyc = 0; w_cyc = 0; pulses = 0; done = 1'b0; rd = '0;
      for (int c = 1; c <= 60 && !done; c++) begin
         @(posedge clk); #1;
         if (m_axi_awvalid) aw_cyc++;
         if (m_axi_wvalid)  w_cyc++;
         if (ready) begin
            lat = c; done = 1'b1; pulses = 1; rd = rdata; valid = 1'b0;
         end
      end
      valid = 1'b0;
      check("ready_seen", 64'(done), 64'(1));
      repeat (3) begin
         @(posedge clk); #1;
         if (ready) pulses++;
      end
   endtask

   task automatic do_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [3:0] s);
      logic [DW-1:0] rd;
      int lat, awc, wc, pl, slow;
      run_txn(a, d, s, rd, lat, awc, wc, pl);
      for (int b = 0; b < 4; b++)
         if (s[b]) ref_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
      slow = (aw_delay > w_delay) ? aw_delay : w_delay;
      check({tag, "_lat"}, 64'(lat), 64'(slow + 3));
      check({tag, "_pulses"}, 64'(pl), 64'(1));
      check({tag, "_awaddr"}, 64'(last_awaddr), 64'(a & 32'hFFFF_FFFC));
   endtask

   task automatic do_read(input string tag, input logic [AW-1:0] a, output logic [DW-1:0] rd);
      int lat, awc, wc, pl;
      run_txn(a, 32'h0, 4'h0, rd, lat, awc, wc, pl);
      check({tag, "_rdata"}, 64'(rd), 64'(ref_mem[a[5:2]]));
      check({tag, "_lat"}, 64'(lat), 64'(ar_delay + r_delay + 3));
      check({tag, "_pulses"}, 64'(pl), 64'(1));
      check({tag, "_araddr"}, 64'(last_araddr), 64'(a & 32'hFFFF_FFFC));
   endtask

   // ---------------- directed steps then random traffic ----------------
   initial begin
      logic [DW-1:0] rd;
      logic [AW-1:0] ra;
      logic [DW-1:0] rdt;
      logic [3:0]    rs;
      int            lat, awc, wc, pl, seen;
      checks = 0; failures = 0;
      rst = 1'b1; valid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
      aw_delay = 0; w_delay = 0; ar_delay = 0; r_delay = 0; inj_r = 1'b0; inj_b = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      check("rst_ready", 64'(ready), 64'(0));
      check("rst_rdata", 64'(rdata), 64'(0));
      check("rst_err", 64'(err), 64'(0));
      check("rst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 64'(0));
      check("rst_readies", 64'({m_axi_bready, m_axi_rready}), 64'(0));

      for (int i = 0; i < 16; i++) do_write("fill", 32'(i * 4), $urandom, 4'hF);

      do_write("wr_a5", 32'h10, 32'hA5A5_1234, 4'hF);
      do_read("rd_a5", 32'h10, rd);
      check("rd_a5_const", 64'(rd), 64'(32'hA5A5_1234));

      do_write("wr_ff", 32'h20, 32'hFFFF_FFFF, 4'hF);
      do_write("wr_strb2", 32'h20, 32'h0000_0000, 4'h2);
      do_read("rd_strb", 32'h20, rd);
      check("rd_strb_const", 64'(rd), 64'(32'hFFFF_00FF));

      aw_delay = 3;
      run_txn(32'h08, 32'h1357_9BDF, 4'hF, rd, lat, awc, wc, pl);
      ref_mem[2] = 32'h1357_9BDF;
      check("awdly_aw_cycles", 64'(awc), 64'(4));
      check("awdly_w_cycles", 64'(wc), 64'(1));
      check("awdly_pulses", 64'(pl), 64'(1));
      check("awdly_lat", 64'(lat), 64'(6));
      aw_delay = 0;
      do_read("awdly_rd", 32'h08, rd);

      r_delay = 5;
      valid = 1'b1; addr = 32'h10; wstrb = 4'h0;
      for (int c = 0; c < 20 && !m_axi_rready; c++) begin
         @(posedge clk); #1;
      end
      check("rd_data_reached", 64'(m_axi_rready), 64'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_ready", 64'(ready), 64'(0));
      check("midrst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 64'(0));
      check("midrst_readies", 64'({m_axi_bready, m_axi_rready}), 64'(0));
      check("midrst_rdata", 64'(rdata), 64'(0));
      rst = 1'b0; valid = 1'b0;
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (ready) seen++;
      end
      check("midrst_no_ready", 64'(seen), 64'(0));
      r_delay = 0;
      do_read("post_rst_rd", 32'h10, rd);

      check("err_before", 64'(err), 64'(0));
      inj_r = 1'b1;
      do_read("slverr_rd", 32'h24, rd);
      inj_r = 1'b0;
      check("err_after_slverr", 64'(err), 64'(ERR_EN));
      do_write("okay_wr", 32'h24, 32'hCAFE_F00D, 4'hF);
      check("err_sticky", 64'(err), 64'(ERR_EN));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("err_cleared", 64'(err), 64'(0));

      do_read("unaligned", 32'h13, rd);
      check("unaligned_araddr", 64'(last_araddr), 64'(32'h10));

      for (int n = 0; n < 40; n++) begin
         aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
         ar_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
         ra  = 32'($urandom_range(0, 63));
         rdt = $urandom;
         rs  = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom_range(1, 15));
         if (rs == 4'h0) do_read("rnd_rd", ra, rd);
         else            do_write("rnd_wr", ra, rdt, rs);
      end

      check("protocol", 64'(proto_err), 64'(0));
      check("err_idle_end", 64'(err), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/iob_axi_bridge.md
IOB_AXI_BRIDGE -- requirements
Module: iob_axi_bridge

Interface
REQ-001 Parameters SHALL be:
- AXI_ID_W, default 4, AXI ID width.
- AXI_LEN_W, default 8, AXI burst-length width.
- AXI_ADDR_W, default `DDR_ADDR_W, AXI and native address width.
- AXI_DATA_W, default `DATA_W (32), data width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- valid  in  1  native request.
- addr  in  AXI_ADDR_W  byte address.
- wdata  in  AXI_DATA_W  write data.
- wstrb  in  AXI_DATA_W/8  byte enables; 0 means read.
- rdata  out  AXI_DATA_W  read data.
- ready  out  1  one-cycle completion pulse.
- m_axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awqos/awvalid  out  per AXI4  write address.
- m_axi_awready  in  1  write address accepted.
- m_axi_wdata/wstrb/wlast/wvalid  out  per AXI4  write data.
- m_axi_wready  in  1  write data accepted.
- m_axi_bid/bresp/bvalid  in  per AXI4  write response.
- m_axi_bready  out  1  write response accepted.
- m_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arqos/arvalid  out  per AXI4  read address.
- m_axi_arready  in  1  read address accepted.
- m_axi_rid/rdata/rresp/rlast/rvalid  in  per AXI4  read data.
- m_axi_rready  out  1  read data accepted.
- err  out  1  sticky response error (see Configuration).

Function
REQ-003 The block SHALL be an AXI4 initiator converting each native request into exactly one single-beat transaction: len=0, size=log2(AXI_DATA_W/8), burst=INCR, id=0, lock/cache/prot/qos=0, wlast=1.
REQ-004 The AXI address SHALL be addr with its low log2(AXI_DATA_W/8) bits forced to 0.
REQ-005 The FSM SHALL have states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA.
- IDLE: valid and wstrb!=0 goes to WR_ADDR_DATA; valid and wstrb==0 goes to RD_ADDR.
- addr/wdata/wstrb SHALL be registered on leaving IDLE.
REQ-006 WR_ADDR_DATA SHALL assert awvalid and wvalid together, each dropped independently on its own handshake; the state moves to WR_RESP once both handshakes have occurred, which may be in the same or different cycles in either order.
REQ-007 WR_RESP SHALL hold bready=1; on bvalid, ready pulses for one cycle on the next clock and the state returns to IDLE.
REQ-008 RD_ADDR SHALL hold arvalid until arready; RD_DATA SHALL hold rready=1.
REQ-009 On rvalid, rdata SHALL be registered, ready pulses on the next clock, and the state returns to IDLE.
REQ-010 rdata SHALL hold its value until the next read completes; ready SHALL be low for writes except the completion pulse.
REQ-011 Minimum latency with always-ready subordinate: valid sampled at cycle 0, AXI valids at cycle 1, response accepted at cycle 2, ready at cycle 3.
REQ-012 Once asserted, any AXI valid SHALL stay asserted with stable payload until its handshake.
REQ-013 The initiator SHALL keep at most one transaction outstanding; valid seen while not IDLE SHALL be ignored until the return to IDLE. The initiator holds valid until ready.

Reset
REQ-014 On rst, the next edge SHALL force IDLE and set ready, all AXI valids, bready, rready, rdata and err to 0, including mid-transaction.
REQ-015 A transaction aborted by reset SHALL never produce ready.

Configuration
REQ-016 With IOB_AXI_BRIDGE_ERR_EN defined, bresp or rresp other than OKAY SHALL set err, which stays 1 until rst; the transaction still completes normally.
REQ-017 Without IOB_AXI_BRIDGE_ERR_EN, err SHALL be tied to 0 and response codes ignored.

Structure
REQ-018 FSM state encodings and AXI constants (INCR, OKAY, size encoding) SHALL live in a shared package header.
REQ-019 No sub-module; a single flat FSM.

Verification
REQ-020 The bench SHALL cover these directed scenarios against an axi_ram subordinate:
- Write 0xA5A5_1234 to 0x10 with wstrb=0xF, then read 0x10: rdata=0xA5A5_1234, ready 3 cycles after valid.
- Write 0xFFFF_FFFF then 0x0000_0000 with wstrb=0x2 to 0x20; read returns 0xFFFF_00FF.
- awready delayed 3 cycles while wready is immediate: wvalid drops after 1 cycle, awvalid holds 4 cycles, single ready pulse.
- rst asserted during RD_DATA: no ready, all valids 0 next cycle; a subsequent read succeeds.
- With IOB_AXI_BRIDGE_ERR_EN, rresp=SLVERR injected: err=1 persists across the next OKAY write and clears only on rst.
- Read of unaligned address 0x13 issues araddr=0x10.
